// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR input feeder.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head: the oldest entry is
// always visible on head_data, and pop simply advances past it.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == LVL_W'(DEPTH));
    assign level     = level_reg;
    assign head_data = mem[rd_ptr_reg];

    // Pointers are exactly AW bits wide, so the natural rollover is the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

endmodule

// File: rtl/fir_axis_feeder.sv
// Buffers strobed ADC samples and presents them to a FIR as an AXI-Stream
// master through a registered output stage, with drop statistics.
module fir_axis_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   sample_valid,
    input  logic [DATA_W-1:0]      sample_data,
    input  logic                   m_axis_data_tready,
    output logic                   m_axis_data_tvalid,
    output logic [DATA_W-1:0]      m_axis_data_tdata,
    input  logic                   clr_stat,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    state_t                  state_reg, state_next;
    logic                    tvalid_reg, tvalid_next;
    logic [DATA_W-1:0]       tdata_reg, tdata_next;
    logic                    overflow_reg, overflow_next;
    logic [DROP_CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;

    logic [DATA_W-1:0]       fifo_head;
    logic                    fifo_empty, fifo_full;
    logic [$clog2(DEPTH):0]  fifo_level;

    logic in_run, accept, drop, out_free, fifo_pop, bypass, fifo_push;

    // Full is judged on the registered level, so a same-cycle pop never makes room.
    assign in_run   = (state_reg == RUN);
    assign accept   = in_run && sample_valid && !fifo_full;
    assign drop     = in_run && sample_valid && fifo_full;
    assign out_free = !tvalid_reg || m_axis_data_tready;
    assign fifo_pop = out_free && !fifo_empty;
    // With nothing buffered the sample goes straight to the output stage.
    assign bypass    = out_free && fifo_empty && accept;
    assign fifo_push = accept && !bypass;

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sample_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if (fifo_empty && !tvalid_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tvalid_next = tvalid_reg;
        tdata_next  = tdata_reg;
        if (out_free) begin
            if (!fifo_empty) begin
                tvalid_next = 1'b1;
                tdata_next  = fifo_head;
            end else if (accept) begin
                tvalid_next = 1'b1;
                tdata_next  = sample_data;
            end else begin
                tvalid_next = 1'b0;
            end
        end
    end

    // A drop wins over a simultaneous clear, restarting the count at one.
    always_comb begin
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            overflow_next = 1'b1;
            if (clr_stat) begin
                drop_cnt_next = DROP_CNT_W'(1);
            end else if (drop_cnt_reg != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
            end
        end else if (clr_stat) begin
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tvalid_reg   <= 1'b0;
            tdata_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tvalid_reg   <= tvalid_next;
            tdata_reg    <= tdata_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign m_axis_data_tvalid = tvalid_reg;
    assign m_axis_data_tdata  = tdata_reg;
    assign overflow           = overflow_reg;
    assign drop_cnt           = drop_cnt_reg;
    assign level              = fifo_level;
    assign busy               = (state_reg != IDLE);

endmodule

// File: tb/tb_fir_axis_feeder.sv
// Directed and randomized checks of fir_axis_feeder against a queue-based model.
module tb_fir_axis_feeder;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              m_axis_data_tready = 1'b0;
    logic              clr_stat = 1'b0;
    logic              m_axis_data_tvalid;
    logic [DATA_W-1:0] m_axis_data_tdata;
    logic              overflow;
    logic [15:0]       drop_cnt;
    logic [LVL_W-1:0]  level;
    logic              busy;

    int nvec = 0;
    int nerr = 0;

    // Reference model: 0=idle 1=run 2=drain, a queue for storage, one output slot.
    int                m_state = 0;
    logic [DATA_W-1:0] mq[$];
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_ovf = 1'b0;
    int                m_drop = 0;

    fir_axis_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .sample_valid       (sample_valid),
        .sample_data        (sample_data),
        .m_axis_data_tready (m_axis_data_tready),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .clr_stat           (clr_stat),
        .overflow           (overflow),
        .drop_cnt           (drop_cnt),
        .level              (level),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int  nxt;
        bit  take, lost, handshake, was_empty;
        if (rst) begin
            m_state = 0; mq.delete(); m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_drop = 0;
            return;
        end
        was_empty = (mq.size() == 0) && !m_valid;
        take      = (m_state == 1) && sample_valid && (mq.size() < DEPTH);
        lost      = (m_state == 1) && sample_valid && (mq.size() == DEPTH);
        handshake = m_valid && m_axis_data_tready;
        nxt = m_state;
        if (m_state == 0 && en) nxt = 1;
        else if (m_state == 1 && !en) nxt = 2;
        else if (m_state == 2) nxt = en ? 1 : (was_empty ? 0 : 2);
        if (lost) begin
            m_ovf  = 1'b1;
            m_drop = clr_stat ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
        end else if (clr_stat) begin
            m_ovf = 1'b0; m_drop = 0;
        end
        if (!m_valid || handshake) begin
            if (mq.size() > 0) begin
                m_data = mq.pop_front(); m_valid = 1'b1;
            end else if (take) begin
                m_data = sample_data; m_valid = 1'b1; take = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (take) mq.push_back(sample_data);
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic begin_run();
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; m_axis_data_tready = 1'b0; clr_stat = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1;
        tick();
    endtask

    task automatic push_n(input int n, input logic [DATA_W-1:0] base);
        for (int i = 1; i <= n; i++) begin
            sample_valid = 1'b1; sample_data = base + DATA_W'(i);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sample_valid = 1'b1; sample_data = 16'h5555; clr_stat = 1'b1;
        m_axis_data_tready = 1'b0;
        tick(); tick();
        nvec++; if (m_axis_data_tvalid !== 1'b0) begin nerr++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_data_tvalid); end
        nvec++; if (m_axis_data_tdata !== 16'h0) begin nerr++; $display("FAIL reset_tdata: got %0h expected 0", m_axis_data_tdata); end
        nvec++; if (level !== '0) begin nerr++; $display("FAIL reset_level: got %0d expected 0", level); end
        nvec++; if (overflow !== 1'b0 || drop_cnt !== 16'h0) begin nerr++; $display("FAIL reset_stats: got ovf=%0b cnt=%0h expected 0/0", overflow, drop_cnt); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        sample_valid = 1'b0; clr_stat = 1'b0; en = 1'b0;
    endtask

    task automatic test_passthrough();
        begin_run();
        m_axis_data_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sample_valid = 1'b1; sample_data = DATA_W'(i);
            tick();
            $display("xfer passthrough: tvalid=%0b tdata=%0h level=%0d", m_axis_data_tvalid, m_axis_data_tdata, level);
            nvec++; if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== DATA_W'(i)) begin nerr++; $display("FAIL pass_word%0d: got v=%0b d=%0h expected v=1 d=%0h", i, m_axis_data_tvalid, m_axis_data_tdata, i); end
            nvec++; if (level !== '0) begin nerr++; $display("FAIL pass_level%0d: got %0d expected 0", i, level); end
        end
        sample_valid = 1'b0;
        tick();
        nvec++; if (m_axis_data_tvalid !== 1'b0) begin nerr++; $display("FAIL pass_idle: got tvalid=%0b expected 0", m_axis_data_tvalid); end
    endtask

    task automatic test_overflow();
        int got;
        begin_run();
        push_n(10, 16'h0100);
        nvec++; if (level !== LVL_W'(DEPTH)) begin nerr++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
        nvec++; if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'h0101) begin nerr++; $display("FAIL ovf_held: got v=%0b d=%0h expected v=1 d=101", m_axis_data_tvalid, m_axis_data_tdata); end
        nvec++; if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin nerr++; $display("FAIL ovf_stats: got cnt=%0d ovf=%0b expected 1/1", drop_cnt, overflow); end
        m_axis_data_tready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
            if (m_axis_data_tvalid) begin
                $display("xfer drain: tdata=%0h", m_axis_data_tdata);
                nvec++; if (m_axis_data_tdata !== DATA_W'(16'h0101 + got)) begin nerr++; $display("FAIL ovf_order%0d: got %0h expected %0h", got, m_axis_data_tdata, 16'h0101 + got); end
                got++;
            end
            tick();
        end
        nvec++; if (got != 9) begin nerr++; $display("FAIL ovf_count: got %0d words expected 9", got); end
        nvec++; if (m_axis_data_tvalid !== 1'b0 || level !== '0) begin nerr++; $display("FAIL ovf_empty: got v=%0b level=%0d expected 0/0", m_axis_data_tvalid, level); end
    endtask

    task automatic test_drain_hold();
        begin_run();
        sample_valid = 1'b1; sample_data = 16'h1234;
        tick();
        sample_valid = 1'b0; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            nvec++; if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'h1234 || busy !== 1'b1) begin nerr++; $display("FAIL hold%0d: got v=%0b d=%0h busy=%0b expected 1/1234/1", k, m_axis_data_tvalid, m_axis_data_tdata, busy); end
        end
        m_axis_data_tready = 1'b1;
        tick();
        nvec++; if (m_axis_data_tvalid !== 1'b0) begin nerr++; $display("FAIL hold_release: got tvalid=%0b expected 0", m_axis_data_tvalid); end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL drain_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_full_pop_drop();
        begin_run();
        push_n(9, 16'h0200);
        nvec++; if (level !== LVL_W'(DEPTH) || drop_cnt !== 16'd0) begin nerr++; $display("FAIL fpd_pre: got level=%0d cnt=%0d expected %0d/0", level, drop_cnt, DEPTH); end
        m_axis_data_tready = 1'b1; sample_valid = 1'b1; sample_data = 16'hdead;
        tick();
        sample_valid = 1'b0; m_axis_data_tready = 1'b0;
        nvec++; if (level !== LVL_W'(DEPTH - 1)) begin nerr++; $display("FAIL fpd_level: got %0d expected %0d", level, DEPTH - 1); end
        nvec++; if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin nerr++; $display("FAIL fpd_stats: got cnt=%0d ovf=%0b expected 1/1", drop_cnt, overflow); end
        nvec++; if (m_axis_data_tdata !== 16'h0202) begin nerr++; $display("FAIL fpd_next: got %0h expected 202", m_axis_data_tdata); end
    endtask

    task automatic test_saturation();
        begin_run();
        push_n(9, 16'h0300);
        sample_valid = 1'b1;
        for (int k = 0; k < 65535; k++) tick();
        nvec++; if (drop_cnt !== 16'hffff) begin nerr++; $display("FAIL sat_reach: got %0h expected ffff", drop_cnt); end
        tick();
        nvec++; if (drop_cnt !== 16'hffff || overflow !== 1'b1) begin nerr++; $display("FAIL sat_hold: got cnt=%0h ovf=%0b expected ffff/1", drop_cnt, overflow); end
        sample_valid = 1'b0; clr_stat = 1'b1;
        tick();
        nvec++; if (drop_cnt !== 16'h0 || overflow !== 1'b0) begin nerr++; $display("FAIL sat_clear: got cnt=%0h ovf=%0b expected 0/0", drop_cnt, overflow); end
        sample_valid = 1'b1;
        tick();
        nvec++; if (drop_cnt !== 16'h1 || overflow !== 1'b1) begin nerr++; $display("FAIL clr_vs_drop: got cnt=%0h ovf=%0b expected 1/1", drop_cnt, overflow); end
        sample_valid = 1'b0; clr_stat = 1'b0;
    endtask

    task automatic test_reset_midstream();
        begin_run();
        push_n(6, 16'h0400);
        nvec++; if (level !== LVL_W'(5) || m_axis_data_tvalid !== 1'b1) begin nerr++; $display("FAIL mid_pre: got level=%0d v=%0b expected 5/1", level, m_axis_data_tvalid); end
        rst = 1'b1;
        tick();
        nvec++; if (m_axis_data_tvalid !== 1'b0 || level !== '0 || busy !== 1'b0) begin nerr++; $display("FAIL mid_reset: got v=%0b level=%0d busy=%0b expected 0/0/0", m_axis_data_tvalid, level, busy); end
        rst = 1'b0; en = 1'b1; m_axis_data_tready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++; if (m_axis_data_tvalid !== 1'b0) begin nerr++; $display("FAIL mid_stale%0d: got tvalid=%0b d=%0h expected 0", k, m_axis_data_tvalid, m_axis_data_tdata); end
        end
        sample_valid = 1'b1; sample_data = 16'hbeef;
        tick();
        sample_valid = 1'b0;
        nvec++; if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'hbeef) begin nerr++; $display("FAIL mid_fresh: got v=%0b d=%0h expected 1/beef", m_axis_data_tvalid, m_axis_data_tdata); end
        tick();
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) en = ~en;
            sample_valid       = ($urandom_range(2) != 0);
            sample_data        = DATA_W'($urandom);
            m_axis_data_tready = ($urandom_range(2) == 0);
            clr_stat           = ($urandom_range(49) == 0);
            rst                = ($urandom_range(499) == 0);
            tick();
            nvec++; if (m_axis_data_tvalid !== m_valid || (m_valid && m_axis_data_tdata !== m_data)) begin nerr++; $display("FAIL rnd_out@%0d: got v=%0b d=%0h expected v=%0b d=%0h", c, m_axis_data_tvalid, m_axis_data_tdata, m_valid, m_data); end
            nvec++; if (level !== LVL_W'(mq.size()) || busy !== (m_state != 0)) begin nerr++; $display("FAIL rnd_lvl@%0d: got level=%0d busy=%0b expected %0d/%0b", c, level, busy, mq.size(), m_state != 0); end
            nvec++; if (overflow !== m_ovf || drop_cnt !== 16'(m_drop)) begin nerr++; $display("FAIL rnd_stat@%0d: got ovf=%0b cnt=%0d expected %0b/%0d", c, overflow, drop_cnt, m_ovf, m_drop); end
        end
        rst = 1'b0; clr_stat = 1'b0; sample_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_overflow();
        test_drain_hold();
        test_full_pop_drop();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
